rs_alu: RTL

RS_ALU -- requirements
Module: rs_alu

---
 rtl/rs_alu.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rs_alu.sv
// Reservation station feeding the integer ALU: holds issued instructions until both
// operands are available (issue bypass + CDB snoop), then dispatches one per cycle.
module rs_alu #(
   parameter int unsigned RS_SIZE = 8,
   parameter int unsigned ROB_W   = 4
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              flush_in,

   input  logic              issue_valid,
   input  logic [10:0]       issue_op,
   input  logic [31:0]       issue_pc,
   input  logic [31:0]       issue_imm,
   input  logic              issue_is_short,
   input  logic [ROB_W-1:0]  issue_rob_id,
   input  logic              issue_q1_busy,
   input  logic [ROB_W-1:0]  issue_q1,
   input  logic [31:0]       issue_v1,
   input  logic              issue_q2_busy,
   input  logic [ROB_W-1:0]  issue_q2,
   input  logic [31:0]       issue_v2,
   output logic              full_out,

   input  logic              cdb_alu_valid,
   input  logic [ROB_W-1:0]  cdb_alu_rob_id,
   input  logic [31:0]       cdb_alu_value,
   input  logic              cdb_lsb_valid,
   input  logic [ROB_W-1:0]  cdb_lsb_rob_id,
   input  logic [31:0]       cdb_lsb_value,

   output logic              alu_yes,
   output logic [10:0]       alu_op,
   output logic [31:0]       alu_v1,
   output logic [31:0]       alu_v2,
   output logic [31:0]       alu_pc,
   output logic [31:0]       alu_imm,
   output logic              alu_is_short,
   output logic [ROB_W-1:0]  alu_rob_id
);

   localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int unsigned OP_W  = 11;
   localparam int unsigned XLEN  = 32;

   // entry storage
   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] q1_busy;
   logic [RS_SIZE-1:0] q2_busy;
   logic [RS_SIZE-1:0] is_short;
   logic [OP_W-1:0]    op     [RS_SIZE];
   logic [XLEN-1:0]    pc     [RS_SIZE];
   logic [XLEN-1:0]    imm    [RS_SIZE];
   logic [ROB_W-1:0]   rob_id [RS_SIZE];
   logic [ROB_W-1:0]   q1     [RS_SIZE];
   logic [ROB_W-1:0]   q2     [RS_SIZE];
   logic [XLEN-1:0]    v1     [RS_SIZE];
   logic [XLEN-1:0]    v2     [RS_SIZE];

   logic [RS_SIZE-1:0] ready;
   logic               free_found;
   logic               ready_found;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   ready_idx;
   logic               do_issue;
   logic               do_dispatch;

   logic [RS_SIZE-1:0] hit1;
   logic [RS_SIZE-1:0] hit2;
   logic [XLEN-1:0]    snp_v1 [RS_SIZE];
   logic [XLEN-1:0]    snp_v2 [RS_SIZE];

   logic               iss_q1_busy;
   logic               iss_q2_busy;
   logic [XLEN-1:0]    iss_v1;
   logic [XLEN-1:0]    iss_v2;

   // full and ready reflect registered state only, so a same-cycle dispatch never frees a slot early
   assign full_out    = &busy;
   assign ready       = busy & ~q1_busy & ~q2_busy;
   assign do_issue    = issue_valid & ~full_out & rdy_in & ~flush_in;
   assign do_dispatch = ready_found & rdy_in & ~flush_in;

   // lowest-index free and ready entries
   always_comb begin
      free_found  = 1'b0;
      ready_found = 1'b0;
      free_idx    = '0;
      ready_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ready[i]) begin
            ready_found = 1'b1;
            ready_idx   = IDX_W'(i);
         end
      end
   end

   // per-entry CDB tag match; the ALU bus takes priority on a double hit
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         hit1[i]   = 1'b0;
         hit2[i]   = 1'b0;
         snp_v1[i] = v1[i];
         snp_v2[i] = v2[i];
         if (cdb_alu_valid && (q1[i] == cdb_alu_rob_id)) begin
            hit1[i]   = 1'b1;
            snp_v1[i] = cdb_alu_value;
         end else if (cdb_lsb_valid && (q1[i] == cdb_lsb_rob_id)) begin
            hit1[i]   = 1'b1;
            snp_v1[i] = cdb_lsb_value;
         end
         if (cdb_alu_valid && (q2[i] == cdb_alu_rob_id)) begin
            hit2[i]   = 1'b1;
            snp_v2[i] = cdb_alu_value;
         end else if (cdb_lsb_valid && (q2[i] == cdb_lsb_rob_id)) begin
            hit2[i]   = 1'b1;
            snp_v2[i] = cdb_lsb_value;
         end
      end
   end

   // issue-time bypass of a result broadcast in the same cycle
   always_comb begin
      iss_q1_busy = issue_q1_busy;
      iss_q2_busy = issue_q2_busy;
      iss_v1      = issue_v1;
      iss_v2      = issue_v2;
      if (issue_q1_busy) begin
         if (cdb_alu_valid && (issue_q1 == cdb_alu_rob_id)) begin
            iss_q1_busy = 1'b0;
            iss_v1      = cdb_alu_value;
         end else if (cdb_lsb_valid && (issue_q1 == cdb_lsb_rob_id)) begin
            iss_q1_busy = 1'b0;
            iss_v1      = cdb_lsb_value;
         end
      end
      if (issue_q2_busy) begin
         if (cdb_alu_valid && (issue_q2 == cdb_alu_rob_id)) begin
            iss_q2_busy = 1'b0;
            iss_v2      = cdb_alu_value;
         end else if (cdb_lsb_valid && (issue_q2 == cdb_lsb_rob_id)) begin
            iss_q2_busy = 1'b0;
            iss_v2      = cdb_lsb_value;
         end
      end
   end

   // station state and dispatch registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy         <= '0;
         q1_busy      <= '0;
         q2_busy      <= '0;
         is_short     <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op[i]     <= '0;
            pc[i]     <= '0;
            imm[i]    <= '0;
            rob_id[i] <= '0;
            q1[i]     <= '0;
            q2[i]     <= '0;
            v1[i]     <= '0;
            v2[i]     <= '0;
         end
         alu_yes      <= 1'b0;
         alu_op       <= '0;
         alu_v1       <= '0;
         alu_v2       <= '0;
         alu_pc       <= '0;
         alu_imm      <= '0;
         alu_is_short <= 1'b0;
         alu_rob_id   <= '0;
      end else if (rdy_in) begin
         alu_yes <= do_dispatch;
         if (flush_in) begin
            busy <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && q1_busy[i] && hit1[i]) begin
                  q1_busy[i] <= 1'b0;
                  v1[i]      <= snp_v1[i];
               end
               if (busy[i] && q2_busy[i] && hit2[i]) begin
                  q2_busy[i] <= 1'b0;
                  v2[i]      <= snp_v2[i];
               end
            end
            if (do_dispatch) begin
               busy[ready_idx] <= 1'b0;
               alu_op          <= op[ready_idx];
               alu_v1          <= v1[ready_idx];
               alu_v2          <= v2[ready_idx];
               alu_pc          <= pc[ready_idx];
               alu_imm         <= imm[ready_idx];
               alu_is_short    <= is_short[ready_idx];
               alu_rob_id      <= rob_id[ready_idx];
            end
            // issue targets a slot free in registered state, so it never collides with dispatch
            if (do_issue && free_found) begin
               busy[free_idx]     <= 1'b1;
               op[free_idx]       <= issue_op;
               pc[free_idx]       <= issue_pc;
               imm[free_idx]      <= issue_imm;
               is_short[free_idx] <= issue_is_short;
               rob_id[free_idx]   <= issue_rob_id;
               q1_busy[free_idx]  <= iss_q1_busy;
               q1[free_idx]       <= issue_q1;
               v1[free_idx]       <= iss_v1;
               q2_busy[free_idx]  <= iss_q2_busy;
               q2[free_idx]       <= issue_q2;
               v2[free_idx]       <= iss_v2;
            end
         end
      end else begin
         alu_yes <= 1'b0;
      end
   end

endmodule
